score_seg7_display: RTL and testbench

- Consumer end of the two-digit BCD score counter: takes the current score and best score as BCD digit pairs.
- Drives a 4-digit common-anode seven-segment display by time-multiplexing the digits.
- Features: tear-free frame snapshots, leading-zero blanking, invalid-code indication and score blinking (e.g. game over).
- Sits between the score counters and the board display pins.

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/bcd_to_seg7.sv | 28 ++
 rtl/score_seg7_display.sv | 137 +++++++++++++
 tb/tb_score_seg7_display.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for seven-segment displays: segment patterns for the
// ten decimal digits, the dash and blank patterns, and the digit slot map.
package seg7_pkg;

    // Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [3:0] AN_OFF   = 4'b1111;

    typedef logic [1:0] slot_t;

    // Slot number equals the anode index it drives.
    localparam slot_t SLOT_SCORE_ONE = 2'd0;
    localparam slot_t SLOT_SCORE_TEN = 2'd1;
    localparam slot_t SLOT_BEST_ONE  = 2'd2;
    localparam slot_t SLOT_BEST_TEN  = 2'd3;

    // Active-low one-hot anode pattern for a slot.
    function automatic logic [3:0] an_for_slot(input slot_t slot);
        return ~(4'b0001 << slot);
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder (active-low segments).
// Non-decimal codes 10..15 show a dash so corrupt counter values are visible.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Pure lookup; every code maps to a defined pattern.
    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/score_seg7_display.sv
// Four-digit multiplexed score/best-score display driver.
// Digits are snapshotted once per frame so a frame never mixes old and new
// values; tens digits can be zero-blanked and the score digits can blink.
module score_seg7_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] score_one,
    input  logic [3:0] score_ten,
    input  logic [3:0] best_one,
    input  logic [3:0] best_ten,
    input  logic       blank_zero,
    input  logic       blink,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0] div_count_reg;
    logic [FRM_W-1:0] frame_count_reg;
    slot_t            slot_reg;
    logic             blink_phase_reg;
    logic [3:0]       shadow_reg [4];
    logic [3:0]       digit_in   [4];

    logic       tick;
    logic       frame_end;
    logic [3:0] cur_digit;
    logic [6:0] dec_seg;
    logic       blink_blank;
    logic       zero_blank;
    logic       blanked;

    assign tick      = (div_count_reg == DIV_LAST);
    assign frame_end = tick && (slot_reg == SLOT_BEST_TEN);

    assign digit_in[SLOT_SCORE_ONE] = score_one;
    assign digit_in[SLOT_SCORE_TEN] = score_ten;
    assign digit_in[SLOT_BEST_ONE]  = best_one;
    assign digit_in[SLOT_BEST_TEN]  = best_ten;

    // Slot-period divider, free running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_count_reg <= '0;
        end else if (tick) begin
            div_count_reg <= '0;
        end else begin
            div_count_reg <= div_count_reg + 1'b1;
        end
    end

    // Slot pointer advances at the end of each slot period and wraps 3 -> 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_reg <= SLOT_SCORE_ONE;
        end else if (tick) begin
            slot_reg <= slot_reg + 2'd1;
        end
    end

    // Shadow digits reload only at the frame boundary (tear-free frames).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_shadow
            // Per-digit snapshot register.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    shadow_reg[gi] <= 4'd0;
                end else if (frame_end) begin
                    shadow_reg[gi] <= digit_in[gi];
                end
            end
        end
    endgenerate

    // Blink timing: count frames while blinking, toggle phase on wrap;
    // held at zero whenever blinking is off so each blink starts visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_count_reg <= '0;
            blink_phase_reg <= 1'b0;
        end else if (!blink) begin
            frame_count_reg <= '0;
            blink_phase_reg <= 1'b0;
        end else if (frame_end) begin
            if (frame_count_reg == FRM_LAST) begin
                frame_count_reg <= '0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                frame_count_reg <= frame_count_reg + 1'b1;
            end
        end
    end

    assign cur_digit = shadow_reg[slot_reg];

    bcd_to_seg7 u_decoder (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

    // Blank decision for the current slot.
    always_comb begin
        blink_blank = blink && blink_phase_reg &&
                      ((slot_reg == SLOT_SCORE_ONE) || (slot_reg == SLOT_SCORE_TEN));
        zero_blank  = blank_zero && (cur_digit == 4'd0) &&
                      ((slot_reg == SLOT_SCORE_TEN) || (slot_reg == SLOT_BEST_TEN));
        blanked     = blink_blank || zero_blank;
    end

    // Registered pin drivers, reloaded every cycle from the current slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (blanked) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_for_slot(slot_reg);
            seg <= dec_seg;
            dp  <= (slot_reg == SLOT_BEST_ONE) ? 1'b0 : 1'b1;
        end
    end

endmodule

// File: tb/tb_score_seg7_display.sv
// Self-checking bench for score_seg7_display with a small cycle model
// feeding an expected-output queue, plus directed checks per scenario.
module tb_score_seg7_display;

    localparam int DIV = 4;
    localparam int BF  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] score_one = 4'd0;
    logic [3:0] score_ten = 4'd0;
    logic [3:0] best_one = 4'd0;
    logic [3:0] best_ten = 4'd0;
    logic       blank_zero = 1'b0;
    logic       blink = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    score_seg7_display #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .reset      (reset),
        .score_one  (score_one),
        .score_ten  (score_ten),
        .best_one   (best_one),
        .best_ten   (best_ten),
        .blank_zero (blank_zero),
        .blink      (blink),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    // Reference model: cycle index since reset drives slot timing directly.
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    int          cyc_n = 0;
    int          m_bcount = 0;
    logic [3:0]  m_shadow [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic [11:0] exp_q [$];
    int          m_s;
    logic [3:0]  m_d;
    bit          m_phase, m_blank;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_n = 0;
            m_bcount = 0;
            for (int k = 0; k < 4; k++) m_shadow[k] = 4'd0;
            exp_q.delete();
        end else begin
            m_s = (cyc_n / DIV) % 4;
            m_d = m_shadow[m_s];
            m_phase = ((m_bcount / BF) % 2) == 1;
            m_blank = (blink && m_phase && m_s < 2) ||
                      (blank_zero && (m_s == 1 || m_s == 3) && m_d == 4'd0);
            if (m_blank)
                exp_q.push_back({4'b1111, 7'h7F, 1'b1});
            else
                exp_q.push_back({4'(~(4'b0001 << m_s)), seg_tab[m_d], (m_s == 2) ? 1'b0 : 1'b1});
            if ((cyc_n % DIV) == DIV - 1 && m_s == 3) begin
                m_shadow[0] = score_one;
                m_shadow[1] = score_ten;
                m_shadow[2] = best_one;
                m_shadow[3] = best_ten;
                if (blink) m_bcount++;
            end
            if (!blink) m_bcount = 0;
            cyc_n++;
        end
    end

    // Advance to the next sampling point and fetch the expected output.
    task automatic next_cycle(output logic [11:0] e, output bit ok);
        @(negedge clk);
        ok = exp_q.size() > 0;
        e  = ok ? exp_q.pop_front() : 12'h000;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got=%b exp=1111", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=7f", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp); end
        score_one = 4'd4; score_ten = 4'd2; best_one = 4'd7; best_ten = 4'd9;
        reset = 1'b1;
        $display("reset released, score=24 best=97");
    endtask

    task automatic test_frame();
        logic [3:0]  an_tab [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0]  exp_seg [4] = '{7'h19, 7'h24, 7'h78, 7'h10};
        logic [11:0] e; bit ok; int c, s;
        repeat (32) begin
            next_cycle(e, ok); c = cyc_n - 1; s = (c / DIV) % 4;
            checks++;
            if (!ok || {an, seg, dp} !== e) begin errors++; $display("FAIL frame_model c=%0d got=%h exp=%h", c, {an, seg, dp}, e); end
            if (c >= 16) begin
                checks++;
                if (an !== an_tab[s] || seg !== exp_seg[s] || dp !== (s != 2)) begin
                    errors++; $display("FAIL frame_digits c=%0d got=%b/%h/%b exp=%b/%h/%b", c, an, seg, dp, an_tab[s], exp_seg[s], s != 2);
                end
            end
        end
        $display("frame test done at cycle %0d", cyc_n);
    endtask

    task automatic test_snapshot();
        logic [11:0] e; bit ok; int c, s;
        repeat (5) begin
            next_cycle(e, ok); c = cyc_n - 1;
            checks++; if (!ok || {an, seg, dp} !== e) begin errors++; $display("FAIL snap_model c=%0d got=%h exp=%h", c, {an, seg, dp}, e); end
        end
        score_one = 4'd5;
        repeat (16) begin
            next_cycle(e, ok); c = cyc_n - 1; s = (c / DIV) % 4;
            checks++; if (!ok || {an, seg, dp} !== e) begin errors++; $display("FAIL snap_model c=%0d got=%h exp=%h", c, {an, seg, dp}, e); end
            if (c >= 48 && s == 0) begin
                checks++; if (an !== 4'b1110 || seg !== 7'h12) begin errors++; $display("FAIL snap_new c=%0d got=%b/%h exp=1110/12", c, an, seg); end
            end
        end
        $display("snapshot test done at cycle %0d", cyc_n);
    endtask

    task automatic test_blank_zero();
        logic [11:0] e; bit ok; int c, s;
        blank_zero = 1'b1; score_ten = 4'd0; best_ten = 4'd0;
        repeat (27) begin
            next_cycle(e, ok); c = cyc_n - 1; s = (c / DIV) % 4;
            checks++; if (!ok || {an, seg, dp} !== e) begin errors++; $display("FAIL bz_model c=%0d got=%h exp=%h", c, {an, seg, dp}, e); end
            if (c >= 64 && (s == 1 || s == 3)) begin
                checks++; if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin errors++; $display("FAIL bz_blank c=%0d got=%b/%h/%b exp=1111/7f/1", c, an, seg, dp); end
            end else if (c >= 64 && s == 0) begin
                checks++; if (an !== 4'b1110 || seg !== 7'h12) begin errors++; $display("FAIL bz_units c=%0d got=%b/%h exp=1110/12", c, an, seg); end
            end else if (c >= 64) begin
                checks++; if (an !== 4'b1011 || seg !== 7'h78 || dp !== 1'b0) begin errors++; $display("FAIL bz_best c=%0d got=%b/%h/%b exp=1011/78/0", c, an, seg, dp); end
            end
        end
        $display("blank_zero test done at cycle %0d", cyc_n);
    endtask

    task automatic test_blink();
        logic [11:0] e; bit ok; int c, s, f;
        blank_zero = 1'b0; score_ten = 4'd2; best_ten = 4'd9; blink = 1'b1;
        repeat (116) begin
            next_cycle(e, ok); c = cyc_n - 1; s = (c / DIV) % 4; f = (c - 80) / 16 + 1;
            checks++; if (!ok || {an, seg, dp} !== e) begin errors++; $display("FAIL blink_model c=%0d got=%h exp=%h", c, {an, seg, dp}, e); end
            if (c < 176 && s < 2 && (f == 3 || f == 4)) begin
                checks++; if (an !== 4'b1111) begin errors++; $display("FAIL blink_off c=%0d frame=%0d got=%b exp=1111", c, f, an); end
            end else if (c < 176) begin
                checks++; if (an === 4'b1111) begin errors++; $display("FAIL blink_on c=%0d frame=%0d got=%b exp=visible", c, f, an); end
            end else if (c >= 192) begin
                checks++; if (an !== 4'b1111) begin errors++; $display("FAIL blink_off2 c=%0d got=%b exp=1111", c, an); end
            end
        end
        blink = 1'b0;
        repeat (4) begin
            next_cycle(e, ok); c = cyc_n - 1;
            checks++; if (!ok || {an, seg, dp} !== e) begin errors++; $display("FAIL unblink_model c=%0d got=%h exp=%h", c, {an, seg, dp}, e); end
            checks++; if (an !== 4'b1101 || seg !== 7'h24) begin errors++; $display("FAIL unblink c=%0d got=%b/%h exp=1101/24", c, an, seg); end
        end
        $display("blink test done at cycle %0d", cyc_n);
    endtask

    task automatic test_dash();
        logic [11:0] e; bit ok; int c, s;
        score_one = 4'hC;
        repeat (24) begin
            next_cycle(e, ok); c = cyc_n - 1; s = (c / DIV) % 4;
            checks++; if (!ok || {an, seg, dp} !== e) begin errors++; $display("FAIL dash_model c=%0d got=%h exp=%h", c, {an, seg, dp}, e); end
            if (c >= 208 && s == 0) begin
                checks++; if (an !== 4'b1110 || seg !== 7'h3F) begin errors++; $display("FAIL dash c=%0d got=%b/%h exp=1110/3f", c, an, seg); end
            end
        end
        $display("dash test done at cycle %0d", cyc_n);
    endtask

    task automatic test_reset_mid();
        logic [11:0] e; bit ok; int c;
        repeat (9) begin
            next_cycle(e, ok); c = cyc_n - 1;
            checks++; if (!ok || {an, seg, dp} !== e) begin errors++; $display("FAIL pre_rst_model c=%0d got=%h exp=%h", c, {an, seg, dp}, e); end
        end
        checks++; if (an !== 4'b1011) begin errors++; $display("FAIL pre_rst_slot got=%b exp=1011", an); end
        #2 reset = 1'b0;
        #1;
        checks++; if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin errors++; $display("FAIL async_rst got=%b/%h/%b exp=1111/7f/1", an, seg, dp); end
        blank_zero = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) begin
            next_cycle(e, ok); c = cyc_n - 1;
            checks++; if (!ok || {an, seg, dp} !== e) begin errors++; $display("FAIL post_rst_model c=%0d got=%h exp=%h", c, {an, seg, dp}, e); end
            if (c < 4) begin
                checks++; if (an !== 4'b1110 || seg !== 7'h40) begin errors++; $display("FAIL post_rst_zero c=%0d got=%b/%h exp=1110/40", c, an, seg); end
            end else if (c >= 12 && c < 16) begin
                checks++; if (an !== 4'b1111) begin errors++; $display("FAIL post_rst_bz c=%0d got=%b exp=1111", c, an); end
            end else if (c >= 16) begin
                checks++; if (an !== 4'b1110 || seg !== 7'h3F) begin errors++; $display("FAIL post_rst_load c=%0d got=%b/%h exp=1110/3f", c, an, seg); end
            end
        end
        $display("mid-frame reset test done at cycle %0d", cyc_n);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_snapshot();
        test_blank_zero();
        test_blink();
        test_dash();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
